scc_run_ctrl: RTL and testbench

Run controller sitting directly upstream of `scc_f25_top`. On a start request it drives the core's reset and clock-enable inputs: a reset window, then free-run or single-step execution. It watches `halt_f` and `err_bits`, counts enabled core cycles and ends the run on halt, timeout or abort. It then reports a status code, leaving the core frozen (not reset) for inspection.

---
 rtl/scc_run_ctrl.sv | 91 +++++++++
 tb/tb_scc_run_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scc_run_ctrl.sv
// scc_run_ctrl: sequences reset, free-run or single-step execution of the core and reports why the run ended
module scc_run_ctrl #(
  parameter int RST_CYCLES = 3,
  parameter int TIMEOUT = 750,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  input  logic             halt_f,
  input  logic [1:0]       err_bits,
  output logic             core_rst,
  output logic             core_clk_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [1:0]       err_latched,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RESET, RUN, STEP_WAIT, STEP_ONE, DONE} state_t;
  state_t state;
  logic [RW-1:0] rcnt;
  logic ran, mode;
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cycle_count + CNT_W'(1);
  // before the first run the core is held in reset; afterwards it is left frozen for inspection
  assign core_rst = state == IDLE ? ~ran : state == RESET;
  assign core_clk_en = state inside {RESET, RUN, STEP_ONE};
  assign busy = state inside {RESET, RUN, STEP_WAIT, STEP_ONE};
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ran <= 1'b0;
      mode <= 1'b0;
      rcnt <= '0;
      status <= 2'b00;
      err_latched <= 2'b00;
      cycle_count <= '0;
    end else begin
      if (state inside {RUN, STEP_WAIT, STEP_ONE}) err_latched <= err_latched | err_bits;
      case (state)
        IDLE: if (start) begin
          state <= RESET;
          cycle_count <= '0;
          err_latched <= 2'b00;
          status <= 2'b00;
          mode <= step_mode;
          rcnt <= RW'(RST_CYCLES);
        end
        RESET: begin
          rcnt <= rcnt - RW'(1);
          if (abort) begin
            state <= DONE;
            status <= 2'b11;
            ran <= 1'b1;
          end else if (rcnt == RW'(1)) begin
            state <= mode ? STEP_WAIT : RUN;
            ran <= 1'b1;
          end
        end
        RUN, STEP_ONE: if (abort) begin
          state <= DONE;
          status <= 2'b11;
        end else if (halt_f) begin
          state <= DONE;
          status <= 2'b01;
        end else begin
          cycle_count <= cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state <= DONE;
            status <= 2'b10;
          end else if (state == STEP_ONE) state <= STEP_WAIT;
        end
        STEP_WAIT: if (abort) begin
          state <= DONE;
          status <= 2'b11;
        end else if (halt_f) begin
          state <= DONE;
          status <= 2'b01;
        end else if (step) state <= STEP_ONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scc_run_ctrl.sv
// tb_scc_run_ctrl: randomized runs checked against a per-run outcome model of the run controller
module tb_scc_run_ctrl;
  localparam int RC = 3, TO = 20, CW = 32;
  logic clk = 0, rst = 0, start = 0, step_mode = 0, step = 0, abort = 0, halt_f = 0;
  logic [1:0] err_bits = 0;
  logic core_rst, core_clk_en, busy, done;
  logic [1:0] status, err_latched;
  logic [CW-1:0] cycle_count;
  int errors = 0, checks = 0;
  scc_run_ctrl #(.RST_CYCLES(RC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .abort(abort),
    .halt_f(halt_f), .err_bits(err_bits), .core_rst(core_rst), .core_clk_en(core_clk_en),
    .busy(busy), .done(done), .status(status), .err_latched(err_latched), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string tag, input logic [3:0] exp);
    check(tag, {core_rst, core_clk_en, busy, done}, exp);
  endtask
  task automatic reset_window(input logic drop_abort, input int ra, output bit aborted);
    aborted = 0;
    for (int r = 0; r < RC; r++) begin
      ctl("rst_win", 4'b1110);
      check("rst_win_cnt", cycle_count, 0);
      check("rst_win_status", status, 0);
      check("rst_win_err", err_latched, 0);
      abort = drop_abort && r == ra;
      err_bits = 2'($urandom);
      step = 1'($urandom);
      step_mode = 1'($urandom);
      tick;
      if (abort) begin
        aborted = 1;
        abort = 0;
        return;
      end
    end
    step = 0;
  endtask
  task automatic finish_run(input logic [1:0] st, input int cnt, input logic [1:0] acc);
    halt_f = 0;
    abort = 0;
    step = 0;
    err_bits = 2'($urandom);
    start = 1;
    ctl("done_ctl", 4'b0001);
    check("done_status", status, st);
    check("done_cnt", cycle_count, cnt);
    check("done_err", err_latched, acc);
    tick;
    start = 0;
    ctl("idle_ctl", 4'b0000);
    check("idle_status", status, st);
    check("idle_cnt", cycle_count, cnt);
    check("idle_err", err_latched, acc);
  endtask
  task automatic run_free(input int k, input int ka);
    logic [1:0] acc = 0, st;
    int cnt, e;
    bit ab;
    if (ka <= k && ka < TO) begin st = 2'b11; cnt = ka; e = ka; end
    else if (k < TO) begin st = 2'b01; cnt = k; e = k; end
    else begin st = 2'b10; cnt = TO; e = TO - 1; end
    start = 1;
    step_mode = 0;
    tick;
    start = 0;
    reset_window(0, 0, ab);
    for (int i = 0; i <= e; i++) begin
      ctl("run_ctl", 4'b0110);
      check("run_cnt", cycle_count, i);
      halt_f = i == k;
      abort = i == ka;
      err_bits = 2'($urandom);
      acc |= err_bits;
      start = 1'($urandom);
      step = 1'($urandom);
      tick;
    end
    finish_run(st, cnt, acc);
  endtask
  task automatic run_reset_abort(input int ra);
    bit ab;
    start = 1;
    step_mode = 1'($urandom);
    tick;
    start = 0;
    reset_window(1, ra, ab);
    check("rst_abort_taken", ab, 1);
    finish_run(2'b11, 0, 2'b00);
  endtask
  task automatic run_step(input int n);
    logic [1:0] acc = 0;
    bit ab;
    start = 1;
    step_mode = 1;
    tick;
    start = 0;
    reset_window(0, 0, ab);
    for (int s = 0; s < n; s++) begin
      for (int w = $urandom_range(0, 2); w >= 0; w--) begin
        ctl("wait_ctl", 4'b0010);
        check("wait_cnt", cycle_count, s);
        step = w == 0;
        err_bits = 2'($urandom);
        acc |= err_bits;
        start = 1'($urandom);
        tick;
      end
      ctl("one_ctl", 4'b0110);
      step = 1'($urandom);
      err_bits = 2'($urandom);
      acc |= err_bits;
      tick;
    end
    ctl("wait_ctl", 4'b0010);
    check("wait_cnt", cycle_count, n);
    halt_f = 1;
    step = 0;
    err_bits = 2'($urandom);
    acc |= err_bits;
    tick;
    finish_run(2'b01, n, acc);
  endtask
  task automatic run_midreset;
    bit ab;
    start = 1;
    step_mode = 0;
    tick;
    start = 0;
    reset_window(0, 0, ab);
    for (int i = 0; i < 5; i++) begin
      err_bits = 2'b11;
      tick;
    end
    rst = 0;
    tick;
    ctl("mid_rst_ctl", 4'b1000);
    check("mid_rst_status", status, 0);
    check("mid_rst_cnt", cycle_count, 0);
    check("mid_rst_err", err_latched, 0);
    rst = 1;
    err_bits = 0;
    tick;
    ctl("mid_rst_idle", 4'b1000);
  endtask
  initial begin
    tick;
    tick;
    ctl("reset_ctl", 4'b1000);
    check("reset_status", status, 0);
    check("reset_err", err_latched, 0);
    check("reset_cnt", cycle_count, 0);
    rst = 1;
    tick;
    ctl("pre_run_idle", 4'b1000);
    run_free(7, 99);
    run_free(99, 99);
    run_free(TO - 1, 99);
    run_free(3, 3);
    run_reset_abort(1);
    run_step(4);
    run_midreset;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: run_reset_abort($urandom_range(0, RC - 1));
        1: run_step($urandom_range(1, 5));
        default: run_free($urandom_range(0, 25), $urandom_range(0, 2) == 0 ? $urandom_range(0, 25) : 99);
      endcase
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        step = 1'($urandom);
        tick;
        ctl("gap_idle", 4'b0000);
      end
      step = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
